ex_mem_reg: RTL and testbench
=============================

Name: ex_mem_reg

Overview:
EX→MEM pipeline boundary that sits directly downstream of the 32-bit shifter and the ALU. It selects the EX result from the ALU, the shifter (sll32 output) or the link address. The selected result and control bits are captured into a 2-entry skid buffer. The buffer exposes valid/ready handshakes on both sides, so MEM back-pressure never creates a combinational path into EX.

Parameters:
DATA_W, 32, datapath width (result, store data, PC)
RA_W, 5, register-file address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset (asserted when 0)
flush  in  1  kill all buffered entries (branch mispredict / exception)
in_valid  in  1  EX presents an instruction
in_ready  out  1  buffer can accept; registered
ex_sel  in  2  result select: 0=ALU, 1=SHIFT, 2=LINK (pc+8), 3=zero
alu_res  in  DATA_W  ALU result
shift_res  in  DATA_W  shifter result
pc_plus8  in  DATA_W  link address
store_data  in  DATA_W  rt value for stores
rd  in  RA_W  destination register
reg_we  in  1  register write enable
mem_re  in  1  load
mem_we  in  1  store
out_valid  out  1  head entry valid
out_ready  in  1  MEM accepts head entry
out_res  out  DATA_W  selected EX result of head entry
out_store_data  out  DATA_W  head store data
out_rd  out  RA_W  head destination
out_reg_we  out  1  head register write enable
out_mem_re  out  1  head load
out_mem_we  out  1  head store

Behaviour:
- Reset (rst==0 at edge): both entries invalid. in_ready=1, out_valid=0. All out_* data/control = 0. Reset mid-transfer discards in-flight data.
- Result mux is combinational at the input. Only the muxed value is stored; ex_sel is not stored.
- rd==0 forces the stored reg_we to 0 (r0 never written).
- Storage: head entry (drives out_*) plus skid entry. Occupancy count 0..2.
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- Occupancy 0: accept → head, next out_valid=1.
- Occupancy 1:
  - Accept and pop in the same cycle: new data → head, count stays 1.
  - Accept only: data → skid, count=2.
  - Pop only: count=0.
- Occupancy 2: in_ready=0, so accept is impossible. Pop moves skid → head, count=1.
- in_ready is registered: next in_ready = (next count < 2). A producer seeing in_ready=1 is always accepted; there is no combinational in_ready←out_ready path.
- Latency: accepted input appears on out_* exactly 1 cycle later when the buffer was empty.
- flush (synchronous, rst has priority): next count=0, out_valid=0, in_ready=1. flush overrides accept and pop in the same cycle; the input is dropped and the MEM pop is ignored.
- When out_valid=0, out_* hold their last values, except that out_reg_we, out_mem_re and out_mem_we are forced to 0.
- No state machine beyond the occupancy count (EMPTY, ONE, FULL). Transitions are as listed above, and no other transitions exist.

Optional Feature:
EX_MEM_FWD_EN
- Defined: adds outputs fwd_valid (1), fwd_rd (RA_W) and fwd_res (DATA_W). These are driven combinationally from the head entry. fwd_valid = out_valid && out_reg_we && !out_mem_re (loads cannot forward from this stage). The hazard unit uses them for EX→EX forwarding. fwd_* = 0 when the head is invalid.
- Not defined: the ports do not exist and there is no extra logic. The hazard unit stalls instead.

Decomposition:
- Shared package ex_pkg: DATA_W/RA_W defaults, ex_sel encodings (EXSEL_ALU, EXSEL_SHIFT, EXSEL_LINK, EXSEL_ZERO), and an ex_mem_entry struct (res, store_data, rd, reg_we, mem_re, mem_we).
- One natural sub-module: ex_skid_buf, the generic 2-entry valid/ready buffer over the packed entry.
- ex_mem_reg adds the mux, the rd==0 rule, flush and the forwarding tap.

Test Plan:
- Reset, then send ex_sel=1, shift_res=0x0000_0F00, rd=5, reg_we=1 with out_ready=1 → next cycle out_valid=1, out_res=0x0000_0F00, out_rd=5, out_reg_we=1.
- rd=0, reg_we=1, alu_res=0xDEAD_BEEF → out_res=0xDEAD_BEEF, out_reg_we=0.
- Hold out_ready=0 and send 3 back-to-back inputs (A, B, C) → A and B accepted, in_ready=0 the cycle after B, C held. Release out_ready → A, B, C emerge in order with no loss or duplication.
- Buffer full (count=2), then assert flush and in_valid together → next cycle out_valid=0, in_ready=1, nothing emerges afterwards.
- Drop rst to 0 mid-stream with count=2 → next cycle out_valid=0, out_res=0, in_ready=1. Resume with ex_sel=2, pc_plus8=0x0040_0008 → out_res=0x0040_0008.
- With EX_MEM_FWD_EN: load (mem_re=1, rd=7) → fwd_valid=0. Then ALU op with rd=7, res=0x10 → fwd_valid=1, fwd_rd=7, fwd_res=0x10.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types for the EX->MEM boundary: default widths, result-select
// encodings and the packed entry held by the skid buffer.
package ex_pkg;

  localparam int unsigned EX_DATA_W = 32;
  localparam int unsigned EX_RA_W   = 5;

  typedef enum logic [1:0] {
    EXSEL_ALU   = 2'd0,
    EXSEL_SHIFT = 2'd1,
    EXSEL_LINK  = 2'd2,
    EXSEL_ZERO  = 2'd3
  } ex_sel_e;

  typedef struct packed {
    logic [EX_DATA_W-1:0] res;
    logic [EX_DATA_W-1:0] store_data;
    logic [EX_RA_W-1:0]   rd;
    logic                 reg_we;
    logic                 mem_re;
    logic                 mem_we;
  } ex_mem_entry_t;

  // EX result select; only the selected value travels down the pipe.
  function automatic logic [EX_DATA_W-1:0] ex_result(
    input ex_sel_e              sel,
    input logic [EX_DATA_W-1:0] alu,
    input logic [EX_DATA_W-1:0] shift,
    input logic [EX_DATA_W-1:0] link
  );
    logic [EX_DATA_W-1:0] r;
    r = '0;
    unique case (sel)
      EXSEL_ALU:   r = alu;
      EXSEL_SHIFT: r = shift;
      EXSEL_LINK:  r = link;
      EXSEL_ZERO:  r = '0;
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ex_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. The head entry drives the output;
// the skid entry absorbs one extra beat so in_ready can be registered.
module ex_skid_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

  occ_e             state_q, state_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, pop;

  assign accept    = in_valid && in_ready_q;
  assign pop       = (state_q != StEmpty) && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign out_data  = head_q;

  // Occupancy transitions and entry movement; flush drops everything.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          head_d  = in_data;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && pop) begin
          head_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = StFull;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      // Head keeps its old contents so out_* data hold their last values.
      state_d = StEmpty;
      head_d  = head_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != StFull);
  end

  // State and entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StEmpty;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: result mux, r0 write suppression, flush and a
// 2-entry skid buffer. Define EX_MEM_FWD_EN to add the EX->EX forwarding tap.
// DATA_W/RA_W must match the widths of ex_pkg::ex_mem_entry_t.
module ex_mem_reg
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = EX_DATA_W,
  parameter int unsigned RA_W   = EX_RA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ex_sel,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] shift_res,
  input  logic [DATA_W-1:0] pc_plus8,
  input  logic [DATA_W-1:0] store_data,
  input  logic [RA_W-1:0]   rd,
  input  logic              reg_we,
  input  logic              mem_re,
  input  logic              mem_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [DATA_W-1:0] out_store_data,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_reg_we,
  output logic              out_mem_re,
  output logic              out_mem_we
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [RA_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_res
`endif
);

  ex_mem_entry_t in_entry;
  ex_mem_entry_t head;

  // Build the entry to store; r0 is never written.
  always_comb begin
    in_entry            = '0;
    in_entry.res        = ex_result(ex_sel_e'(ex_sel), alu_res, shift_res, pc_plus8);
    in_entry.store_data = store_data;
    in_entry.rd         = rd;
    in_entry.reg_we     = reg_we && (rd != '0);
    in_entry.mem_re     = mem_re;
    in_entry.mem_we     = mem_we;
  end

  ex_skid_buf #(
    .Width($bits(ex_mem_entry_t))
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_entry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head)
  );

  // Data outputs hold while idle; control outputs are qualified by valid.
  always_comb begin
    out_res        = head.res;
    out_store_data = head.store_data;
    out_rd         = head.rd;
    out_reg_we     = out_valid && head.reg_we;
    out_mem_re     = out_valid && head.mem_re;
    out_mem_we     = out_valid && head.mem_we;
  end

`ifdef EX_MEM_FWD_EN
  // Loads cannot forward from this stage; their data is not ready yet.
  always_comb begin
    fwd_valid = out_valid && head.reg_we && !head.mem_re;
    fwd_rd    = out_valid ? head.rd  : '0;
    fwd_res   = out_valid ? head.res : '0;
  end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  ex_sel;
  logic [31:0] alu_res, shift_res, pc_plus8, store_data;
  logic [4:0]  rd;
  logic        reg_we, mem_re, mem_we;
  logic [31:0] out_res, out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_we, out_mem_re, out_mem_we;
`ifdef EX_MEM_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_res;
`endif

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ex_sel        (ex_sel),
    .alu_res       (alu_res),
    .shift_res     (shift_res),
    .pc_plus8      (pc_plus8),
    .store_data    (store_data),
    .rd            (rd),
    .reg_we        (reg_we),
    .mem_re        (mem_re),
    .mem_we        (mem_we),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_res       (out_res),
    .out_store_data(out_store_data),
    .out_rd        (out_rd),
    .out_reg_we    (out_reg_we),
    .out_mem_re    (out_mem_re),
    .out_mem_we    (out_mem_we)
`ifdef EX_MEM_FWD_EN
    ,
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_res       (fwd_res)
`endif
  );

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        we;
    logic        re;
    logic        mwe;
  } ent_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] shift;
    logic [31:0] pc8;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] exp_res;
    logic        exp_we;
  } vec_t;

  ent_t q[$];
  ent_t last;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of capacity 2 whose front is what MEM sees.
  function automatic ent_t model_entry();
    ent_t e;
    case (ex_sel)
      2'd0:    e.res = alu_res;
      2'd1:    e.res = shift_res;
      2'd2:    e.res = pc_plus8;
      default: e.res = 32'h0;
    endcase
    e.sd  = store_data;
    e.rd  = rd;
    e.we  = reg_we && (rd != 5'd0);
    e.re  = mem_re;
    e.mwe = mem_we;
    return e;
  endfunction

  task automatic check_outputs();
    bit v;
    v = (q.size() > 0);
    chk("out_valid", {63'd0, out_valid}, {63'd0, v});
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("out_res", {32'd0, out_res}, {32'd0, last.res});
    chk("out_store_data", {32'd0, out_store_data}, {32'd0, last.sd});
    chk("out_rd", {59'd0, out_rd}, {59'd0, last.rd});
    chk("out_ctrl", {61'd0, out_reg_we, out_mem_re, out_mem_we},
        {61'd0, v && last.we, v && last.re, v && last.mwe});
`ifdef EX_MEM_FWD_EN
    chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, v && last.we && !last.re});
    chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, v ? last.rd : 5'd0});
    chk("fwd_res", {32'd0, fwd_res}, {32'd0, v ? last.res : 32'd0});
`endif
  endtask

  // One clock: predict from pre-edge inputs, advance, compare.
  task automatic cycle();
    ent_t e;
    bit   acc, pop;
    e   = model_entry();
    acc = in_valid && (q.size() < 2);
    pop = (q.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (!rst) begin
      q.delete();
      last = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (q.size() > 0) last = q[0];
    check_outputs();
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] sh,
                       input logic [31:0] pc8, input logic [4:0] r, input logic we,
                       input logic re, input logic mwe);
    in_valid   = 1'b1;
    ex_sel     = sel;
    alu_res    = alu;
    shift_res  = sh;
    pc_plus8   = pc8;
    store_data = alu ^ 32'h5A5A_0000;
    rd         = r;
    reg_we     = we;
    mem_re     = re;
    mem_we     = mwe;
  endtask

  vec_t vecs[6];

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ex_sel = 2'd0; alu_res = '0; shift_res = '0; pc_plus8 = '0; store_data = '0;
    rd = '0; reg_we = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    last = '0;

    vecs[0] = '{2'd1, 32'h1111_1111, 32'h0000_0F00, 32'h0, 5'd5, 1'b1, 32'h0000_0F00, 1'b1};
    vecs[1] = '{2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{2'd2, 32'h1, 32'h2, 32'h0040_0008, 5'd31, 1'b1, 32'h0040_0008, 1'b1};
    vecs[3] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, 32'h0, 1'b0};
    vecs[4] = '{2'd0, 32'h8000_0001, 32'h0, 32'h0, 5'd1, 1'b1, 32'h8000_0001, 1'b1};
    vecs[5] = '{2'd1, 32'h0, 32'hFFFF_FFFE, 32'h0, 5'd0, 1'b0, 32'hFFFF_FFFE, 1'b0};

    // Reset state.
    cycle();
    cycle();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_res", {32'd0, out_res}, 64'd0);
    rst = 1'b1;
    cycle();

    // Directed vectors, each through an empty buffer.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].sel, vecs[i].alu, vecs[i].shift, vecs[i].pc8, vecs[i].rd, vecs[i].we,
            1'b0, 1'b0);
      cycle();
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d_res", i), {32'd0, out_res}, {32'd0, vecs[i].exp_res});
      chk($sformatf("vec%0d_we", i), {63'd0, out_reg_we}, {63'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_rd", i), {59'd0, out_rd}, {59'd0, vecs[i].rd});
      in_valid = 1'b0;
      cycle();
    end

    // Back-pressure: A, B accepted, C held until space frees up.
    out_ready = 1'b0;
    drive(2'd0, 32'hAAAA_0001, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(2'd0, 32'hBBBB_0002, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("bp_in_ready_after_b", {63'd0, in_ready}, 64'd0);
    drive(2'd0, 32'hCCCC_0003, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("bp_head_a", {32'd0, out_res}, 64'hAAAA_0001);
    out_ready = 1'b1;
    cycle();
    chk("bp_head_b", {32'd0, out_res}, 64'hBBBB_0002);
    cycle();
    chk("bp_head_c", {32'd0, out_res}, 64'hCCCC_0003);
    in_valid = 1'b0;
    cycle();
    chk("bp_drained", {63'd0, out_valid}, 64'd0);

    // Flush while full, with a concurrent input that must be dropped.
    out_ready = 1'b0;
    drive(2'd0, 32'h0000_00F1, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1);
    cycle();
    drive(2'd0, 32'h0000_00F2, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
    cycle();
    drive(2'd0, 32'h0000_00F3, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    cycle();
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("flush_nothing_after", {63'd0, out_valid}, 64'd0);
    end

    // Reset mid-stream with the buffer full.
    out_ready = 1'b0;
    drive(2'd1, 32'h0, 32'h1234_5678, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(2'd1, 32'h0, 32'h8765_4321, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    cycle();
    rst = 1'b0;
    cycle();
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_out_res", {32'd0, out_res}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b1; out_ready = 1'b1;
    drive(2'd2, 32'h0, 32'h0, 32'h0040_0008, 5'd31, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("resume_link", {32'd0, out_res}, 64'h0040_0008);
    in_valid = 1'b0;
    cycle();

`ifdef EX_MEM_FWD_EN
    drive(2'd0, 32'h0000_0099, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    cycle();
    chk("fwd_load_blocked", {63'd0, fwd_valid}, 64'd0);
    drive(2'd0, 32'h0000_0010, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    cycle();
    chk("fwd_alu_valid", {63'd0, fwd_valid}, 64'd1);
    chk("fwd_alu_rd", {59'd0, fwd_rd}, 64'd7);
    chk("fwd_alu_res", {32'd0, fwd_res}, 64'h10);
    in_valid = 1'b0;
    cycle();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 63) != 0);
      ex_sel     = 2'($urandom_range(0, 3));
      alu_res    = $urandom;
      shift_res  = $urandom;
      pc_plus8   = $urandom;
      store_data = $urandom;
      rd         = 5'($urandom_range(0, 7));
      reg_we     = 1'($urandom_range(0, 1));
      mem_re     = 1'($urandom_range(0, 1));
      mem_we     = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
